// File: rtl/my_divider_pkg.sv
// my_divider_pkg
//   Shared definitions for the restoring divider: the default operand width and
//   the encodings of the three-state control FSM.
package my_divider_pkg;

  // Default operand width (quotient and remainder share it).
  localparam int DEFAULT_WIDTH = 8;

  // FSM encodings, kept as plain 2-bit constants for legacy tools.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/my_divider_fsubtractor.sv
// my_fsubtractor
//   One-bit full subtractor cell used to build the ripple-borrow trial subtract.
//   Ports:
//     A     in  minuend bit
//     B     in  subtrahend bit
//     B_in  in  borrow from the next less significant cell
//     D     out difference bit, A - B - B_in
//     B_out out borrow towards the next more significant cell
module my_fsubtractor (
  input  logic A,
  input  logic B,
  input  logic B_in,
  output logic D,
  output logic B_out
);

  assign D     = A ^ B ^ B_in;
  assign B_out = (~A & B) | (B_in & ~(A ^ B));

endmodule

// File: rtl/my_divider.sv
// my_divider
//   Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   Ports:
//     clk          in   rising-edge clock
//     rst          in   asynchronous reset, active-high
//     start        in   request, sampled only while idle
//     dividend     in   numerator, captured when start is accepted
//     divisor      in   denominator, captured when start is accepted
//     busy         out  high while iterating
//     done         out  one-cycle pulse, results valid from this cycle
//     quotient     out  result, held until replaced by the next result
//     remainder    out  result, held until replaced by the next result
//     div_by_zero  out  set together with done when divisor was zero
import my_divider_pkg::*;

module my_divider #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  // Trial subtract: T = {P, Q msb} is WIDTH+1 bits wide, so the shifted
  // partial remainder never loses its top bit even for full-scale operands.
  logic [WIDTH:0]   t_s;
  logic [WIDTH:0]   sub_b_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH+1:0] borrow_s;
  logic             restore_s;
  logic [WIDTH-1:0] p_next_s;
  logic [WIDTH-1:0] q_next_s;

  assign t_s         = {p_q, q_q[WIDTH-1]};
  assign sub_b_s     = {1'b0, divisor_q};
  assign borrow_s[0] = 1'b0;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
    my_fsubtractor u_fsub (
      .A     (t_s[i]),
      .B     (sub_b_s[i]),
      .B_in  (borrow_s[i]),
      .D     (diff_s[i]),
      .B_out (borrow_s[i+1])
    );
  end

  // P < divisor is invariant, so a borrow-free difference always fits in WIDTH
  // bits; diff_s[WIDTH] can only be set alongside a borrow and is folded in so
  // the select covers every bit the chain produces.
  assign restore_s = borrow_s[WIDTH+1] | diff_s[WIDTH];
  assign p_next_s  = restore_s ? t_s[WIDTH-1:0] : diff_s[WIDTH-1:0];
  assign q_next_s  = {q_q[WIDTH-2:0], ~restore_s};

  // Next-state, iteration and result-register logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    p_d         = p_q;
    q_d         = q_q;
    divisor_d   = divisor_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          divisor_d = divisor;
          dbz_d     = 1'b0;
          if (divisor == {WIDTH{1'b0}}) begin
            // Results are loaded on the way into DONE so they are valid
            // in the same cycle as the done pulse.
            state_d     = DONE;
            done_d      = 1'b1;
            quotient_d  = {WIDTH{1'b1}};
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = CALC;
            busy_d  = 1'b1;
            count_d = CNT_W'(WIDTH - 1);
            p_d     = {WIDTH{1'b0}};
            q_d     = dividend;
          end
        end else begin
          state_d = IDLE;
        end
      end

      CALC: begin
        p_d = p_next_s;
        q_d = q_next_s;
        if (count_q == {CNT_W{1'b0}}) begin
          state_d     = DONE;
          done_d      = 1'b1;
          quotient_d  = q_next_s;
          remainder_d = p_next_s;
        end else begin
          count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
          busy_d  = 1'b1;
        end
      end

      DONE: begin
        // start is deliberately ignored here.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= {CNT_W{1'b0}};
      p_q         <= {WIDTH{1'b0}};
      q_q         <= {WIDTH{1'b0}};
      divisor_q   <= {WIDTH{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      p_q         <= p_d;
      q_q         <= q_d;
      divisor_q   <= divisor_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_my_divider.sv
// tb_my_divider
//   Directed and random stimulus for my_divider with a scoreboard of expected
//   results pushed at request time and popped when done pulses.
module tb_my_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  my_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Issue one request at the next falling edge and follow it to done.
  // inj_cyc > 1 pulses a 10/3 request in that cycle of the operation.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int inj_cyc);
    exp_t e;
    int   cyc;
    int   lat;
    @(negedge clk);
    chk("idle_done_low", 32'(done), 32'(0));
    chk("idle_busy_low", 32'(busy), 32'(0));
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    push_model(a, b);
    lat = (b == '0) ? 1 : W + 1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
      if (inj_cyc > 1 && cyc == inj_cyc) begin
        start = 1'b1; dividend = 8'd10; divisor = 8'd3;
      end
      if (inj_cyc > 1 && cyc == inj_cyc + 1) start = 1'b0;
      if (done !== 1'b1) chk("busy_during_op", 32'(busy), 32'(b != '0));
    end while (done !== 1'b1 && cyc < 40);
    start = 1'b0;
    chk("done_seen", 32'(done), 32'(1));
    chk("latency", 32'(cyc), 32'(lat));
    chk("busy_at_done", 32'(busy), 32'(0));
    chk("sb_size", 32'(sb.size()), 32'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("quotient", 32'(quotient), 32'(e.q));
      chk("remainder", 32'(remainder), 32'(e.r));
      chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_q", 32'(quotient), 32'(0));
    chk("rst_r", 32'(remainder), 32'(0));
    chk("rst_dbz", 32'(div_by_zero), 32'(0));
    rst = 1'b0;

    run_op(8'd100, 8'd7, 0);
    run_op(8'd255, 8'd1, 0);
    run_op(8'd5, 8'd9, 0);
    run_op(8'd255, 8'd255, 0);
    run_op(8'd77, 8'd0, 0);
    run_op(8'd9, 8'd3, 0);

    // 10/3 pulsed mid-calculation must be dropped.
    run_op(8'd200, 8'd13, 4);
    // start held in the DONE cycle must also be dropped.
    start = 1'b1; dividend = 8'd10; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("dropped_busy", 32'(busy), 32'(0));
      chk("dropped_done", 32'(done), 32'(0));
      @(negedge clk);
    end
    chk("held_q", 32'(quotient), 32'(15));
    chk("held_r", 32'(remainder), 32'(5));

    // Reset in cycle 4 of 100/7 aborts without a done pulse.
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_q", 32'(quotient), 32'(0));
    chk("abort_r", 32'(remainder), 32'(0));
    chk("abort_dbz", 32'(div_by_zero), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", 32'(done), 32'(0));
    end
    run_op(8'd50, 8'd6, 0);

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(1, 255));
      run_op(ra, rb, 0);
      chk("identity", 32'(quotient) * 32'(rb) + 32'(remainder), 32'(ra));
      chk("r_lt_d", 32'(remainder < rb), 32'(1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
